// File: rtl/cpu_trace_unit_if.sv
// CPU-side bus between the 6502 core and the trace unit: bus snoop inputs plus READY back to the core.
interface cpu_trace_unit_if;
  logic        clk_en;
  logic        SYNC;
  logic        RnW;
  logic [15:0] Address_bus;
  logic [7:0]  Data_bus;
  logic        READY;

  modport master (output clk_en, SYNC, RnW, Address_bus, Data_bus, input READY);
  modport slave  (input clk_en, SYNC, RnW, Address_bus, Data_bus, output READY);
endinterface

// File: rtl/cpu_trace_unit.sv
// Opcode-fetch trace FIFO with breakpoint halt / single-step control of CPU READY.
// Define CPU_TRACE_WRITES_EN to also record CPU write cycles (bit 24 = write flag).
module cpu_trace_unit #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  RESET,
  cpu_trace_unit_if.slave       cpu,
  input  logic [15:0]           brk_addr,
  input  logic                  brk_enable,
  input  logic                  resume,
  input  logic                  step,
  output logic                  halted,
  input  logic                  trace_rd,
  output logic [24:0]           trace_data,
  output logic                  trace_valid,
  output logic [DEPTH_LOG2:0]   trace_count,
  output logic                  trace_overflow,
  input  logic                  clr_overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic [24:0]     mem_q [DEPTH];

  logic            fetch_cap, push, do_push, do_pop, full, empty, bp_hit;
  logic [24:0]     entry;
  logic [PW-1:0]   count;

  assign fetch_cap = cpu.clk_en & cpu.SYNC & cpu.RnW;
`ifdef CPU_TRACE_WRITES_EN
  logic write_cap;
  assign write_cap = cpu.clk_en & ~cpu.RnW;
  assign push      = fetch_cap | write_cap;
  assign entry     = {write_cap, cpu.Data_bus, cpu.Address_bus};
`else
  assign push      = fetch_cap;
  assign entry     = {1'b0, cpu.Data_bus, cpu.Address_bus};
`endif
  // Writes never match: the breakpoint is qualified by the fetch capture only.
  assign bp_hit = fetch_cap & brk_enable & (cpu.Address_bus == brk_addr);

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = trace_rd & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    ovf_d    = clr_overflow ? 1'b0 : ovf_q;
    if (push && full && !do_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= entry;
  end

  assign trace_data     = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign trace_valid    = ~empty;
  assign trace_count    = count;
  assign trace_overflow = ovf_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (bp_hit) state_d = HALT;
      HALT: if (resume) state_d = RUN;
            else if (step) state_d = STEP;
      STEP: if (fetch_cap) state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cpu.READY = (state_q != HALT);
    halted    = (state_q == HALT);
  end
endmodule
